ram_port_arbiter: RTL and testbench

Two-master arbiter for the data read/write port of the core's dual-port RAM. It shares the single write port and single data-read port between the core load/store unit (master 0) and the program loader/debug master (master 1), one access per cycle. It issues combinational grants and registers read data for a one-cycle response. The instruction-fetch port of the RAM is not touched by this block.

---
 rtl/ram_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the RAM write port and data-read port between
// master 0 (load/store unit) and master 1 (loader/debug), one access per cycle.
// Grants are combinational; read data is registered for a one-cycle response.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default is fixed priority with a starvation guard for master 1).
module ram_port_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          wen,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          ren,
    output logic [AW-1:0] r_addr,
    input  logic [DW-1:0] r_data
);

    // Arbitration decision before the reset gate.
    logic gnt0_raw;
    logic gnt1_raw;

    // Grants are suppressed while reset is held.
    assign m0_gnt = gnt0_raw & ~rst;
    assign m1_gnt = gnt1_raw & ~rst;

`ifdef ARB_ROUND_ROBIN_EN

    // Last-grant pointer: 1 means master 1 was granted most recently.
    logic last_q;
    logic last_d;

    // Favour the master not granted most recently; a lone requester always wins.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        if (m0_req && m1_req) begin
            if (last_q) begin
                gnt0_raw = 1'b1;
            end else begin
                gnt1_raw = 1'b1;
            end
        end else begin
            gnt0_raw = m0_req;
            gnt1_raw = m1_req;
        end
    end

    // Track the most recent winner.
    always_comb begin
        last_d = last_q;
        if (m0_gnt) begin
            last_d = 1'b0;
        end else if (m1_gnt) begin
            last_d = 1'b1;
        end
    end

    // Pointer register; resets to favour master 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

`else

    typedef enum logic [0:0] {
        StNormal  = 1'b0,
        StForceM1 = 1'b1
    } state_e;

    localparam logic [3:0] MaxWait = MAX_WAIT[3:0];

    state_e     state_q;
    state_e     state_d;
    logic [3:0] wait_q;
    logic [3:0] wait_d;

    // Fixed priority to master 0, with master 1 forced through after MaxWait denials.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (m0_req) begin
                    gnt0_raw = 1'b1;
                end else if (m1_req) begin
                    gnt1_raw = 1'b1;
                end
                if (m1_req && !gnt1_raw) begin
                    // Saturating count of consecutive denied cycles.
                    if (wait_q >= MaxWait) begin
                        wait_d = MaxWait;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                    if (wait_d == MaxWait) begin
                        state_d = StForceM1;
                    end
                end else begin
                    wait_d = 4'd0;
                end
            end
            StForceM1: begin
                // A dropped m1_req here is a protocol violation; m0 may then use the slot.
                if (m1_req) begin
                    gnt1_raw = 1'b1;
                end else begin
                    gnt0_raw = m0_req;
                end
                wait_d  = 4'd0;
                state_d = StNormal;
            end
            default: begin
                wait_d  = 4'd0;
                state_d = StNormal;
            end
        endcase
    end

    // Arbiter state and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StNormal;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`endif

    // Steer the winner onto the RAM ports; idle ports are driven to zero.
    always_comb begin
        wen    = 1'b0;
        w_addr = '0;
        w_data = '0;
        ren    = 1'b0;
        r_addr = '0;
        if (m0_gnt) begin
            if (m0_we) begin
                wen    = 1'b1;
                w_addr = m0_addr;
                w_data = m0_wdata;
            end else begin
                ren    = 1'b1;
                r_addr = m0_addr;
            end
        end else if (m1_gnt) begin
            if (m1_we) begin
                wen    = 1'b1;
                w_addr = m1_addr;
                w_data = m1_wdata;
            end else begin
                ren    = 1'b1;
                r_addr = m1_addr;
            end
        end
    end

    logic          rd0_take;
    logic          rd1_take;
    logic          m0_rvalid_q;
    logic          m1_rvalid_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    assign rd0_take = m0_gnt & ~m0_we;
    assign rd1_take = m1_gnt & ~m1_we;

    // Capture read data at the grant edge; rvalid pulses for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= rd0_take;
            m1_rvalid_q <= rd1_take;
            if (rd0_take) begin
                m0_rdata_q <= r_data;
            end
            if (rd1_take) begin
                m1_rdata_q <= r_data;
            end
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vectors, a RAM model, and a
// scoreboard queue of expected read responses checked by a separate monitor.
module tb_ram_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          wen, ren;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data, r_data;

    int tests;
    int fails;

    typedef struct packed {
        logic          m;
        logic [DW-1:0] d;
    } rsp_t;

    rsp_t exp_q[$];

    logic [DW-1:0] mem [0:65535];

    ram_port_arbiter #(
        .DW       (DW),
        .AW       (AW),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .wen       (wen),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .ren       (ren),
        .r_addr    (r_addr),
        .r_data    (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (wen) mem[w_addr] <= w_data;
    end
    assign r_data = mem[r_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read response is matched against the scoreboard head.
    always @(negedge clk) begin
        if (m0_rvalid || m1_rvalid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: rvalid0=%0b rvalid1=%0b with nothing pending",
                         m0_rvalid, m1_rvalid);
            end else begin
                rsp_t e;
                logic [DW-1:0] got;
                e = exp_q.pop_front();
                got = e.m ? m1_rdata : m0_rdata;
                if ({m1_rvalid, m0_rvalid} !== (e.m ? 2'b10 : 2'b01) || got !== e.d) begin
                    fails++;
                    $display("FAIL rsp_m%0d: rvalid={%0b,%0b} rdata=0x%0h expected master %0d data 0x%0h",
                             e.m, m1_rvalid, m0_rvalid, got, e.m, e.d);
                end
            end
        end
    end

    // One arbitration cycle: drive requests, check grant and RAM ports, queue the response.
    task automatic step(input string name,
                        input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1,
                        input int win, input logic [DW-1:0] exp_rd, input bit push);
        logic          e_we, e_wen, e_ren;
        logic [AW-1:0] e_addr, e_waddr, e_raddr;
        logic [DW-1:0] e_wdata;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        e_we    = (win == 1) ? w1 : w0;
        e_addr  = (win == 1) ? a1 : a0;
        e_wen   = (win >= 0) && e_we;
        e_ren   = (win >= 0) && !e_we;
        e_waddr = e_wen ? e_addr : '0;
        e_wdata = e_wen ? ((win == 1) ? d1 : d0) : '0;
        e_raddr = e_ren ? e_addr : '0;
        @(negedge clk);
        chk({name, "_gnt"}, {62'd0, m1_gnt, m0_gnt}, {62'd0, win == 1, win == 0});
        chk({name, "_wport"}, {15'd0, wen, w_addr, w_data}, {15'd0, e_wen, e_waddr, e_wdata});
        chk({name, "_rport"}, {47'd0, ren, r_addr}, {47'd0, e_ren, e_raddr});
        @(posedge clk);
        if (push && win >= 0 && !e_we) exp_q.push_back('{m: (win == 1), d: exp_rd});
        #1;
    endtask

    task automatic idle(input string name);
        step(name, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, -1, 32'h0, 1'b0);
    endtask

    int pat[10];

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0030] = 32'hA0A0A0A0;
        mem[16'h0040] = 32'hB0B0B0B0;
`ifdef ARB_ROUND_ROBIN_EN
        pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

        // Reset held with a live request: nothing may be granted.
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0020; m1_wdata = 32'h1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
        chk("rst_ports", {62'd0, wen, ren}, 64'd0);
        chk("rst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single m0 read.
        step("m0_rd", 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0,
             0, 32'hDEADBEEF, 1'b1);
        idle("idle0");

        // m0 write then m1 read of the same address, back to back.
        step("m0_wr", 1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b0, 1'b0, 16'h0, 32'h0,
             0, 32'h0, 1'b1);
        step("m1_rd", 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0,
             1, 32'h12345678, 1'b1);
        idle("idle1");

        // Both masters hold reads continuously.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("both%0d", i), 1'b1, 1'b0, 16'h0030, 32'h0,
                 1'b1, 1'b0, 16'h0040, 32'h0,
                 pat[i], (pat[i] == 1) ? 32'hB0B0B0B0 : 32'hA0A0A0A0, 1'b1);
        end

        // Lone m1 requester is granted every cycle.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("m1_alone%0d", i), 1'b0, 1'b0, 16'h0, 32'h0,
                 1'b1, 1'b0, 16'h0040, 32'h0, 1, 32'hB0B0B0B0, 1'b1);
        end

        // m0 write then m0 read-after-write.
        step("m0_wr2", 1'b1, 1'b1, 16'h0050, 32'h55AA55AA, 1'b0, 1'b0, 16'h0, 32'h0,
             0, 32'h0, 1'b1);
        step("m0_raw", 1'b1, 1'b0, 16'h0050, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0,
             0, 32'h55AA55AA, 1'b1);
        idle("idle2");

        // m1 read granted, then reset in the response cycle cancels it.
        step("m1_rd_cancel", 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0010, 32'h0,
             1, 32'h0, 1'b0);
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        m1_req = 1'b0;
        @(negedge clk);
        chk("cancel_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
        chk("cancel_ports", {62'd0, wen, ren}, 64'd0);
        chk("cancel_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
        chk("cancel_rdata", {m1_rdata, m0_rdata}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset both request: master 0 goes first in either mode.
        step("post_rst_both", 1'b1, 1'b0, 16'h0030, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0,
             0, 32'hA0A0A0A0, 1'b1);
        idle("idle3");
        idle("idle4");

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
